// File: rtl/cfg_pkg.sv
// Shared types and helpers for the cfg change streamer: word geometry, FSM states
// and the word extractor used by the slot mux.
package cfg_pkg;

    localparam int CFG_WORD_W = 32;
    // Widest cfg bus that word_at can index; narrower buses are zero-extended.
    localparam int CFG_MAX_W  = 4096;
    localparam int WORD_IDX_W = $clog2(CFG_MAX_W / CFG_WORD_W);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SEND
    } state_t;

    // Word idx of the bus; {idx, 5'd0} is idx * 32 at exactly the index width the bus needs.
    function automatic logic [CFG_WORD_W-1:0] word_at(
        input logic [CFG_MAX_W-1:0]  cfg,
        input logic [WORD_IDX_W-1:0] idx
    );
        return cfg[{idx, 5'd0} +: CFG_WORD_W];
    endfunction

endpackage

// File: rtl/cfg_slot_mux.sv
// Combinational select of the scanned slot's word: word[BASE_ADDR + ptr] of the cfg bus.
module cfg_slot_mux
    import cfg_pkg::*;
#(
    parameter int CFG_WIDTH = 1024,
    parameter int BASE_ADDR = 0,
    parameter int IDX_W     = 3
) (
    input  logic [CFG_WIDTH-1:0]  cfg,
    input  logic [IDX_W-1:0]      ptr,
    output logic [CFG_WORD_W-1:0] word
);

    logic [CFG_MAX_W-1:0]  cfg_ext;
    logic [WORD_IDX_W-1:0] word_idx;

    always_comb begin
        cfg_ext                = '0;
        cfg_ext[CFG_WIDTH-1:0] = cfg;
        word_idx               = WORD_IDX_W'(BASE_ADDR) + WORD_IDX_W'(ptr);
        word                   = word_at(cfg_ext, word_idx);
    end

endmodule

// File: rtl/cfg_change_streamer.sv
// Round-robin scan of a window of cfg words; every word that changed or is marked dirty
// is emitted as one registered AXI-Stream beat tagged with its slot index.
module cfg_change_streamer
    import cfg_pkg::*;
#(
    parameter int CFG_WIDTH = 1024,
    parameter int BASE_ADDR = 0,
    parameter int NUM_SLOTS = 8,
    parameter int IDX_W     = 3
) (
    input  logic                  a_clk,
    input  logic                  a_resetn,
    input  logic [CFG_WIDTH-1:0]  cfg,
    input  logic                  enable,
    input  logic                  force_all,
    output logic [CFG_WORD_W-1:0] M_AXIS_tdata,
    output logic [IDX_W-1:0]      M_AXIS_tuser,
    output logic                  M_AXIS_tlast,
    output logic                  M_AXIS_tvalid,
    input  logic                  M_AXIS_tready,
    output logic [31:0]           beat_count
);

    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_SLOTS - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [CFG_WORD_W-1:0] shadow_q [NUM_SLOTS];
    logic [CFG_WORD_W-1:0] shadow_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]  dirty_q, dirty_d;
    logic                  tvalid_q, tvalid_d;
    logic [CFG_WORD_W-1:0] tdata_q, tdata_d;
    logic [IDX_W-1:0]      tuser_q, tuser_d;
    logic                  tlast_q, tlast_d;
    logic [31:0]           beat_count_q, beat_count_d;

    logic [CFG_WORD_W-1:0] slot_word;
    logic                  hit;
    logic [IDX_W-1:0]      next_ptr;

    cfg_slot_mux #(
        .CFG_WIDTH (CFG_WIDTH),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_slot_mux (
        .cfg  (cfg),
        .ptr  (ptr_q),
        .word (slot_word)
    );

    always_comb begin
        // NOTE: every _d starts from its _q so no branch of the case below can infer a latch.
        state_d      = state_q;
        ptr_d        = ptr_q;
        shadow_d     = shadow_q;
        dirty_d      = dirty_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tuser_d      = tuser_q;
        tlast_d      = tlast_q;
        beat_count_d = beat_count_q;

        hit      = dirty_q[ptr_q] | (slot_word != shadow_q[ptr_q]);
        next_ptr = (ptr_q == LAST_SLOT) ? '0 : ptr_q + IDX_W'(1);

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    tdata_d         = slot_word;
                    tuser_d         = ptr_q;
                    tlast_d         = (ptr_q == LAST_SLOT);
                    shadow_d[ptr_q] = slot_word;
                    dirty_d[ptr_q]  = 1'b0;
                    tvalid_d        = 1'b1;
                    state_d         = SEND;
                end else begin
                    ptr_d = next_ptr;
                    if (!enable) begin
                        state_d = IDLE;
                    end
                end
            end
            SEND: begin
                // A presented beat always completes; enable only decides where we go next.
                if (M_AXIS_tready) begin
                    tvalid_d     = 1'b0;
                    beat_count_d = beat_count_q + 32'd1;
                    ptr_d        = next_ptr;
                    state_d      = enable ? SCAN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Applied last so a resend request wins over a same-cycle dirty clear.
        if (force_all) begin
            dirty_d = '1;
        end
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            // NOTE: the shadow array is reset explicitly; it feeds the change compare, so X here would poison hit.
            shadow_q     <= '{default: '0};
            dirty_q      <= '1;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tuser_q      <= '0;
            tlast_q      <= 1'b0;
            beat_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments only, so every flop samples the pre-edge _d values.
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            shadow_q     <= shadow_d;
            dirty_q      <= dirty_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tuser_q      <= tuser_d;
            tlast_q      <= tlast_d;
            beat_count_q <= beat_count_d;
        end
    end

    assign M_AXIS_tvalid = tvalid_q;
    assign M_AXIS_tdata  = tdata_q;
    assign M_AXIS_tuser  = tuser_q;
    assign M_AXIS_tlast  = tlast_q;
    assign beat_count    = beat_count_q;

endmodule

// File: tb/tb_cfg_change_streamer.sv
// Self-checking bench for cfg_change_streamer: a slot-level model (last sent value and dirty
// flag per slot, round-robin order) checked every cycle, plus directed literal expectations.
module tb_cfg_change_streamer;

    localparam int CFG_WIDTH = 1024;
    localparam int BASE_ADDR = 0;
    localparam int NUM_SLOTS = 8;
    localparam int IDX_W     = 3;

    logic                 a_clk = 1'b0;
    logic                 a_resetn;
    logic [CFG_WIDTH-1:0] cfg;
    logic                 enable;
    logic                 force_all;
    logic                 M_AXIS_tready;
    logic [31:0]          M_AXIS_tdata;
    logic [IDX_W-1:0]     M_AXIS_tuser;
    logic                 M_AXIS_tlast;
    logic                 M_AXIS_tvalid;
    logic [31:0]          beat_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 a_clk = ~a_clk;

    cfg_change_streamer #(
        .CFG_WIDTH (CFG_WIDTH),
        .BASE_ADDR (BASE_ADDR),
        .NUM_SLOTS (NUM_SLOTS),
        .IDX_W     (IDX_W)
    ) dut (
        .a_clk         (a_clk),
        .a_resetn      (a_resetn),
        .cfg           (cfg),
        .enable        (enable),
        .force_all     (force_all),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tuser  (M_AXIS_tuser),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready),
        .beat_count    (beat_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] win_word(input int s);
        return cfg[(BASE_ADDR + s) * 32 +: 32];
    endfunction

    // ---------------- model state and accepted-beat log ----------------
    bit          m_dirty [NUM_SLOTS];
    logic [31:0] m_sent  [NUM_SLOTS];
    int          m_ptr, m_cur, m_count;
    int          n_present = 0;
    logic        prev_valid, prev_last;
    logic [31:0] prev_data;
    logic [IDX_W-1:0] prev_user;
    logic [31:0] log_data [$];
    int          log_user [$];
    int          log_last [$];

    // Samples 1 time unit after each rising edge: inputs are those seen at the edge,
    // outputs are the values the edge produced.
    initial begin : compare
        int   found;
        int   s;
        logic acc;
        prev_valid = 1'b0;
        prev_data  = '0;
        prev_user  = '0;
        prev_last  = 1'b0;
        m_ptr      = 0;
        m_cur      = 0;
        m_count    = 0;
        forever begin
            @(posedge a_clk);
            #1;
            if (!a_resetn) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    m_dirty[i] = 1'b1;
                    m_sent[i]  = '0;
                end
                m_ptr      = 0;
                m_count    = 0;
                prev_valid = 1'b0;
                check("reset_tvalid", 32'(M_AXIS_tvalid), 0);
                check("reset_count", beat_count, 0);
            end else begin
                acc = prev_valid && M_AXIS_tready;
                if (prev_valid && !M_AXIS_tready) begin
                    check("hold_tvalid", 32'(M_AXIS_tvalid), 1);
                    check("hold_tdata", M_AXIS_tdata, prev_data);
                    check("hold_tuser", 32'(M_AXIS_tuser), 32'(prev_user));
                    check("hold_tlast", 32'(M_AXIS_tlast), 32'(prev_last));
                end
                if (acc) begin
                    m_count++;
                    log_data.push_back(prev_data);
                    log_user.push_back(int'(prev_user));
                    log_last.push_back(int'(prev_last));
                    m_ptr = (m_cur + 1) % NUM_SLOTS;
                    check("tvalid_drop_after_accept", 32'(M_AXIS_tvalid), 0);
                end
                if (M_AXIS_tvalid && !prev_valid) begin
                    n_present++;
                    found = -1;
                    for (int k = 0; k < NUM_SLOTS; k++) begin
                        s = (m_ptr + k) % NUM_SLOTS;
                        if (found < 0 && (m_dirty[s] || win_word(s) !== m_sent[s])) found = s;
                    end
                    if (found < 0) begin
                        check("spurious_beat", 32'(M_AXIS_tvalid), 0);
                    end else begin
                        check("beat_tuser", 32'(M_AXIS_tuser), 32'(found));
                        check("beat_tdata", M_AXIS_tdata, win_word(found));
                        check("beat_tlast", 32'(M_AXIS_tlast), 32'(found == NUM_SLOTS - 1));
                        m_sent[found]  = win_word(found);
                        m_dirty[found] = 1'b0;
                        m_cur          = found;
                    end
                end
                if (force_all) begin
                    for (int i = 0; i < NUM_SLOTS; i++) m_dirty[i] = 1'b1;
                end
                check("beat_count", beat_count, 32'(m_count));
                prev_valid = M_AXIS_tvalid;
                prev_data  = M_AXIS_tdata;
                prev_user  = M_AXIS_tuser;
                prev_last  = M_AXIS_tlast;
            end
        end
    end

    // ---------------- stimulus helpers (drive on falling edges) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge a_clk);
    endtask

    task automatic set_word(input int s, input logic [31:0] v);
        cfg[(BASE_ADDR + s) * 32 +: 32] = v;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int c = 0;
        while (log_user.size() < n && c < budget) begin
            @(negedge a_clk);
            c++;
        end
        check(name, 32'(log_user.size()), 32'(n));
    endtask

    task automatic wait_valid(input int budget, input string name);
        int c = 0;
        while (!M_AXIS_tvalid && c < budget) begin
            @(negedge a_clk);
            c++;
        end
        check(name, 32'(M_AXIS_tvalid), 1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no end of test, required end within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin : stimulus
        int base;
        int lat;
        int slot_hits [NUM_SLOTS];

        cfg = '0;
        for (int i = 0; i < CFG_WIDTH / 32; i++) begin
            cfg[i * 32 +: 32] = (i < NUM_SLOTS) ? 32'h100 + 32'(i) : 32'hF000_0000 | 32'(i);
        end
        enable        = 1'b0;
        force_all     = 1'b0;
        M_AXIS_tready = 1'b1;
        a_resetn      = 1'b0;
        tick(3);
        check("rst_tvalid", 32'(M_AXIS_tvalid), 0);
        check("rst_tdata", M_AXIS_tdata, 0);
        check("rst_tuser", 32'(M_AXIS_tuser), 0);
        check("rst_tlast", 32'(M_AXIS_tlast), 0);
        check("rst_count", beat_count, 0);

        // First pass after reset: every slot, in order.
        a_resetn = 1'b1;
        enable   = 1'b1;
        wait_log(8, 60, "pass1_beats");
        for (int i = 0; i < NUM_SLOTS; i++) begin
            check("pass1_tuser", 32'(log_user[i]), 32'(i));
            check("pass1_tdata", log_data[i], 32'h100 + 32'(i));
            check("pass1_tlast", 32'(log_last[i]), 32'(i == 7));
        end
        check("pass1_count", beat_count, 8);
        base = n_present;
        tick(100);
        check("quiet_100", 32'(n_present - base), 0);

        // Single change in steady state.
        set_word(5, 32'hDEAD_BEEF);
        lat = 0;
        while (!M_AXIS_tvalid && lat < 20) begin
            @(posedge a_clk);
            #1;
            lat++;
        end
        check("slot5_latency_ok", 32'(M_AXIS_tvalid && lat <= 9), 1);
        wait_log(9, 20, "slot5_beat");
        check("slot5_tuser", 32'(log_user[8]), 5);
        check("slot5_tdata", log_data[8], 32'hDEAD_BEEF);
        check("slot5_count", beat_count, 9);
        tick(20);
        check("slot5_single", 32'(log_user.size()), 9);

        // Backpressure with a change of the stalled slot.
        M_AXIS_tready = 1'b0;
        set_word(2, 32'hAAAA_0002);
        wait_valid(20, "stall_present");
        tick(5);
        set_word(2, 32'h0000_0055);
        tick(15);
        check("stall_tvalid", 32'(M_AXIS_tvalid), 1);
        check("stall_tdata", M_AXIS_tdata, 32'hAAAA_0002);
        check("stall_tuser", 32'(M_AXIS_tuser), 2);
        check("stall_count", beat_count, 9);
        M_AXIS_tready = 1'b1;
        wait_log(11, 30, "stall_beats");
        check("stall_old_tdata", log_data[9], 32'hAAAA_0002);
        check("stall_new_tuser", 32'(log_user[10]), 2);
        check("stall_new_tdata", log_data[10], 32'h0000_0055);

        // force_all in the same cycle as the SCAN hit on slot 3.
        M_AXIS_tready = 1'b0;
        set_word(2, 32'h2222_0002);
        wait_valid(20, "force_present2");
        set_word(3, 32'h3333_0003);
        tick(2);
        M_AXIS_tready = 1'b1;
        tick(1);
        force_all = 1'b1;
        tick(1);
        force_all = 1'b0;
        wait_log(21, 60, "force_beats");
        check("force_first_tuser", 32'(log_user[12]), 3);
        check("force_first_tdata", log_data[12], 32'h3333_0003);
        check("force_last_tuser", 32'(log_user[20]), 3);
        for (int i = 0; i < NUM_SLOTS; i++) slot_hits[i] = 0;
        for (int i = 12; i < 21; i++) slot_hits[log_user[i] % NUM_SLOTS]++;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            check("force_slot_sends", 32'(slot_hits[i]), (i == 3) ? 2 : 1);
        end

        // enable dropped while a beat is in SEND.
        M_AXIS_tready = 1'b0;
        set_word(6, 32'h6666_0006);
        wait_valid(20, "en_present6");
        enable = 1'b0;
        tick(2);
        M_AXIS_tready = 1'b1;
        tick(2);
        check("en_beat_done", 32'(log_user.size()), 22);
        check("en_beat_tuser", 32'(log_user[21]), 6);
        set_word(7, 32'h7777_0007);
        set_word(0, 32'h0000_AAAA);
        set_word(1, 32'h1111_0001);
        base = n_present;
        tick(30);
        check("idle_no_beats", 32'(n_present - base), 0);
        check("idle_count", beat_count, 22);
        enable = 1'b1;
        wait_log(25, 40, "en_resume_beats");
        check("en_resume_t0", 32'(log_user[22]), 7);
        check("en_resume_t1", 32'(log_user[23]), 0);
        check("en_resume_t2", 32'(log_user[24]), 1);
        check("en_resume_d0", log_data[22], 32'h7777_0007);

        // Reset while a beat is presented.
        M_AXIS_tready = 1'b0;
        set_word(4, 32'h4444_0004);
        wait_valid(20, "rst_present");
        #2;
        a_resetn = 1'b0;
        #1;
        check("rst_async_tvalid", 32'(M_AXIS_tvalid), 0);
        check("rst_async_count", beat_count, 0);
        tick(2);
        M_AXIS_tready = 1'b1;
        a_resetn      = 1'b1;
        wait_log(33, 60, "rst_resend_beats");
        for (int i = 0; i < NUM_SLOTS; i++) begin
            check("rst_resend_tuser", 32'(log_user[25 + i]), 32'(i));
        end
        check("rst_resend_slot4", log_data[29], 32'h4444_0004);
        check("rst_resend_count", beat_count, 8);

        tick(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
